// File: rtl/link_align_pkg.sv
// Shared types and helpers for the per-link byte aligner.
package link_align_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WIN_W  = 16;
  localparam int unsigned OFS_W  = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned HYS_W  = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Candidate byte at bit offset k: W[15-k -: 8]
  function automatic logic [BYTE_W-1:0] extract(input logic [WIN_W-1:0] w,
                                                 input logic [OFS_W-1:0] k);
    return BYTE_W'(w >> (4'd8 - {1'b0, k}));
  endfunction

endpackage

// File: rtl/sync_offset_finder.sv
// Combinational search of all 8 bit offsets of the window for the sync byte.
module sync_offset_finder
  import link_align_pkg::*;
(
  input  logic [WIN_W-1:0]  i_win,
  input  logic [BYTE_W-1:0] i_sync,
  output logic              o_found_c,
  output logic [OFS_W-1:0]  o_k_c
);

  // Scan from high to low so the lowest matching offset is the last one written
  always_comb begin
    o_found_c = 1'b0;
    o_k_c     = '0;
    for (int k = 7; k >= 0; k--) begin
      if (extract(i_win, OFS_W'(k)) == i_sync) begin
        o_found_c = 1'b1;
        o_k_c     = OFS_W'(k);
      end
    end
  end

endmodule

// File: rtl/link_word_aligner.sv
// Locks onto the bit offset at which SYNC_WORD repeats every FRAME_LEN bytes and
// emits byte-aligned data with a start-of-frame flag.
module link_word_aligner
  import link_align_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD  = 8'hBC,
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned LOCK_GOOD  = 4,
  parameter int unsigned UNLOCK_BAD = 3
) (
  input  logic              clk160,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [BYTE_W-1:0] out_tdata,
  output logic              out_tvalid,
  output logic              out_tuser,
  input  logic              clr_counters,
  output logic              locked,
  output logic [OFS_W-1:0]  offset,
  output logic [CNT_W-1:0]  lock_loss_count
);

  localparam int unsigned FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  state_t              r_state, w_state_nxt;
  logic [BYTE_W-1:0]   r_prev, r_cur;
  logic                r_upd;
  logic [FCNT_W-1:0]   r_fcnt, w_fcnt_nxt, w_fcnt_inc;
  logic [HYS_W-1:0]    r_good, w_good_nxt, w_good_inc;
  logic [HYS_W-1:0]    r_bad, w_bad_nxt, w_bad_inc;
  logic [OFS_W-1:0]    r_offset, w_offset_nxt;
  logic [BYTE_W-1:0]   r_out_tdata;
  logic                r_out_tvalid, r_out_tuser, r_locked;
  logic [CNT_W-1:0]    r_loss_cnt;
  logic [WIN_W-1:0]    w_win;
  logic [BYTE_W-1:0]   w_cand;
  logic                w_hit, w_bound, w_found, w_loss;
  logic [OFS_W-1:0]    w_k;

  assign w_win      = {r_prev, r_cur};
  assign w_cand     = extract(w_win, r_offset);
  assign w_hit      = (w_cand == SYNC_WORD);
  assign w_bound    = (r_fcnt == '0);
  assign w_fcnt_inc = (r_fcnt == FCNT_W'(FRAME_LEN - 1)) ? '0 : r_fcnt + 1'b1;
  assign w_good_inc = r_good + 1'b1;
  assign w_bad_inc  = r_bad + 1'b1;

  sync_offset_finder u_finder (
    .i_win     (w_win),
    .i_sync    (SYNC_WORD),
    .o_found_c (w_found),
    .o_k_c     (w_k)
  );

  // State register
  always_ff @(posedge clk160) begin
    if (rst) r_state <= SEARCH;
    else     r_state <= w_state_nxt;
  end

  // Next-state and hysteresis counters; evaluation only on window-update cycles
  always_comb begin
    w_state_nxt  = r_state;
    w_fcnt_nxt   = r_fcnt;
    w_good_nxt   = r_good;
    w_bad_nxt    = r_bad;
    w_offset_nxt = r_offset;
    w_loss       = 1'b0;
    if (r_upd) begin
      case (r_state)
        SEARCH: begin
          if (w_found) begin
            w_offset_nxt = w_k;
            w_fcnt_nxt   = FCNT_W'(1);
            w_good_nxt   = HYS_W'(1);
            if (LOCK_GOOD == 32'd1) begin
              w_state_nxt = LOCKED;
              w_bad_nxt   = '0;
            end else begin
              w_state_nxt = VERIFY;
            end
          end
        end
        VERIFY: begin
          w_fcnt_nxt = w_fcnt_inc;
          if (w_bound) begin
            if (w_hit) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == HYS_W'(LOCK_GOOD)) begin
                w_state_nxt = LOCKED;
                w_bad_nxt   = '0;
              end
            end else begin
              w_state_nxt = SEARCH;
            end
          end
        end
        LOCKED: begin
          w_fcnt_nxt = w_fcnt_inc;
          if (w_bound) begin
            if (w_hit) begin
              w_bad_nxt = '0;
            end else begin
              w_bad_nxt = w_bad_inc;
              if (w_bad_inc == HYS_W'(UNLOCK_BAD)) begin
                w_state_nxt = SEARCH;
                w_loss      = 1'b1;
              end
            end
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  // Window, counters and the output register
  always_ff @(posedge clk160) begin
    if (rst) begin
      r_prev       <= '0;
      r_cur        <= '0;
      r_upd        <= 1'b0;
      r_fcnt       <= '0;
      r_good       <= '0;
      r_bad        <= '0;
      r_offset     <= '0;
      r_out_tdata  <= '0;
      r_out_tvalid <= 1'b0;
      r_out_tuser  <= 1'b0;
      r_locked     <= 1'b0;
      r_loss_cnt   <= '0;
    end else begin
      if (in_tvalid) begin
        r_prev <= r_cur;
        r_cur  <= in_tdata;
      end
      r_upd        <= in_tvalid;
      r_fcnt       <= w_fcnt_nxt;
      r_good       <= w_good_nxt;
      r_bad        <= w_bad_nxt;
      r_offset     <= w_offset_nxt;
      r_locked     <= (w_state_nxt == LOCKED);
      r_out_tvalid <= r_upd && (r_state == LOCKED);
      if (r_upd) begin
        r_out_tdata <= w_cand;
        r_out_tuser <= w_bound;
      end
      if (clr_counters)                   r_loss_cnt <= '0;
      else if (w_loss && r_loss_cnt != '1) r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign in_tready       = 1'b1;
  assign out_tdata       = r_out_tdata;
  assign out_tvalid      = r_out_tvalid;
  assign out_tuser       = r_out_tuser;
  assign locked          = r_locked;
  assign offset          = r_offset;
  assign lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_link_word_aligner.sv
// Directed bench: a bit-shifted framed stream at offset 3, expected aligned bytes
// queued as they are driven and popped when the aligner emits them.
module tb_link_word_aligner;

  localparam int FLEN = 16;

  typedef struct packed {
    logic       user;
    logic [7:0] data;
  } exp_t;

  logic        clk160 = 1'b0;
  logic        rst;
  logic [7:0]  in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic [7:0]  out_tdata;
  logic        out_tvalid;
  logic        out_tuser;
  logic        clr_counters;
  logic        locked;
  logic [2:0]  offset;
  logic [15:0] lock_loss_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [2:0] acc3;
  logic [7:0] pend_b;
  logic       pend_u, pend_e;
  bit         gap_mode, prev_ov;

  link_word_aligner #(
    .SYNC_WORD (8'hBC),
    .FRAME_LEN (16),
    .LOCK_GOOD (4),
    .UNLOCK_BAD(3)
  ) dut (
    .clk160          (clk160),
    .rst             (rst),
    .in_tdata        (in_tdata),
    .in_tvalid       (in_tvalid),
    .in_tready       (in_tready),
    .out_tdata       (out_tdata),
    .out_tvalid      (out_tvalid),
    .out_tuser       (out_tuser),
    .clr_counters    (clr_counters),
    .locked          (locked),
    .offset          (offset),
    .lock_loss_count (lock_loss_count)
  );

  initial forever #5 clk160 = ~clk160;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs every cycle on the falling edge: pops and compares each emitted byte
  task automatic monitor();
    exp_t e;
    if (out_tvalid === 1'b1) begin
      if (gap_mode) chk("gap_consec_valid", 32'(prev_ov), 32'd0);
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(out_tvalid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_tdata", 32'(out_tdata), 32'(e.data));
        chk("out_tuser", 32'(out_tuser), 32'(e.user));
      end
    end
    prev_ov = (out_tvalid === 1'b1);
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    in_tvalid = v;
    in_tdata  = d;
    @(posedge clk160);
    @(negedge clk160);
    monitor();
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  // Line byte j carries aligned byte j-1 at offset 3; that byte is evaluated now
  task automatic send_byte(input logic [7:0] b, input logic u, input logic e);
    exp_t x;
    if (pend_e) begin
      x.user = pend_u;
      x.data = pend_b;
      sb.push_back(x);
    end
    cycle(1'b1, {acc3, b[7:3]});
    acc3   = b[2:0];
    pend_b = b;
    pend_u = u;
    pend_e = e;
    if (gap_mode) cycle(1'b0, 8'h00);
  endtask

  // Frame positions lo..hi; position 0 carries sync_b, position fp carries a stray 8'hBC
  task automatic send_frame(input logic [7:0] sync_b, input int fp, input logic e_sync,
                            input logic e_rest, input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      if (p == 0)       send_byte(sync_b, 1'b1, e_sync);
      else if (p == fp) send_byte(8'hBC, 1'b0, e_rest);
      else              send_byte(8'h00, 1'b0, e_rest);
    end
  endtask

  task automatic pulse_reset();
    drain(3);
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    pend_e = 1'b0;
    chk("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    chk("rst_out_tuser", 32'(out_tuser), 32'd0);
    chk("rst_out_tdata", 32'(out_tdata), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_offset", 32'(offset), 32'd0);
    chk("rst_loss_count", 32'(lock_loss_count), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_tvalid = 1'b0; in_tdata = 8'h00; clr_counters = 1'b0;
    acc3 = 3'b000; pend_b = 8'h00; pend_u = 1'b0; pend_e = 1'b0;
    gap_mode = 1'b0; prev_ov = 1'b0;
    @(negedge clk160);
    cycle(1'b0, 8'h00);
    pulse_reset();
    chk("in_tready", 32'(in_tready), 32'd1);

    // Continuous stream at offset 3: lock on the 4th sync, first emitted byte follows it
    repeat (3) send_frame(8'hBC, -1, 1'b0, 1'b0, 0, FLEN - 1);
    chk("lock_not_yet", 32'(locked), 32'd0);
    send_frame(8'hBC, -1, 1'b0, 1'b1, 0, FLEN - 1);
    chk("locked_after_4", 32'(locked), 32'd1);
    chk("offset_3", 32'(offset), 32'd3);
    send_frame(8'hBC, -1, 1'b1, 1'b1, 0, FLEN - 1);

    // Two corrupted syncs are tolerated
    repeat (2) send_frame(8'hB8, -1, 1'b1, 1'b1, 0, FLEN - 1);
    send_frame(8'hBC, -1, 1'b1, 1'b1, 0, FLEN - 1);
    chk("stay_locked", 32'(locked), 32'd1);
    chk("no_loss_yet", 32'(lock_loss_count), 32'd0);

    // Three corrupted syncs drop lock; a stray sync at position 5 then trips VERIFY
    repeat (2) send_frame(8'hB8, -1, 1'b1, 1'b1, 0, FLEN - 1);
    send_frame(8'hB8, 5, 1'b1, 1'b0, 0, FLEN - 1);
    chk("unlock", 32'(locked), 32'd0);
    chk("loss_count_1", 32'(lock_loss_count), 32'd1);
    send_frame(8'hBC, -1, 1'b0, 1'b0, 0, FLEN - 1);
    chk("false_verify_unlocked", 32'(locked), 32'd0);
    repeat (3) send_frame(8'hBC, -1, 1'b0, 1'b0, 0, FLEN - 1);
    send_frame(8'hBC, -1, 1'b0, 1'b1, 0, FLEN - 1);
    send_frame(8'hBC, -1, 1'b1, 1'b1, 0, FLEN - 1);
    chk("relock_true_phase", 32'(locked), 32'd1);
    chk("false_match_no_loss", 32'(lock_loss_count), 32'd1);

    // Reset mid-frame while locked, then relock after four boundaries
    send_frame(8'hBC, -1, 1'b1, 1'b1, 0, 6);
    pulse_reset();
    send_frame(8'hBC, -1, 1'b0, 1'b0, 7, FLEN - 1);
    repeat (3) send_frame(8'hBC, -1, 1'b0, 1'b0, 0, FLEN - 1);
    send_frame(8'hBC, -1, 1'b0, 1'b1, 0, FLEN - 1);
    send_frame(8'hBC, -1, 1'b1, 1'b1, 0, FLEN - 1);
    chk("relock_after_reset", 32'(locked), 32'd1);

    // Gapped input: same lock point in bytes
    pulse_reset();
    gap_mode = 1'b1;
    repeat (3) send_frame(8'hBC, -1, 1'b0, 1'b0, 0, FLEN - 1);
    chk("gap_lock_not_yet", 32'(locked), 32'd0);
    send_frame(8'hBC, -1, 1'b0, 1'b1, 0, FLEN - 1);
    chk("gap_locked", 32'(locked), 32'd1);
    chk("gap_offset", 32'(offset), 32'd3);
    send_frame(8'hBC, -1, 1'b1, 1'b1, 0, FLEN - 1);
    drain(3);
    gap_mode = 1'b0;

    // Saturation of the lock-loss counter, then clear
    force dut.r_loss_cnt = 16'hFFFE;
    drain(1);
    release dut.r_loss_cnt;
    repeat (2) send_frame(8'hB8, -1, 1'b1, 1'b1, 0, FLEN - 1);
    send_frame(8'hB8, -1, 1'b1, 1'b0, 0, FLEN - 1);
    chk("count_ffff", 32'(lock_loss_count), 32'h0000_FFFF);
    repeat (3) send_frame(8'hBC, -1, 1'b0, 1'b0, 0, FLEN - 1);
    send_frame(8'hBC, -1, 1'b0, 1'b1, 0, FLEN - 1);
    chk("relock_for_sat", 32'(locked), 32'd1);
    repeat (2) send_frame(8'hB8, -1, 1'b1, 1'b1, 0, FLEN - 1);
    send_frame(8'hB8, -1, 1'b1, 1'b0, 0, FLEN - 1);
    chk("sat_unlock", 32'(locked), 32'd0);
    chk("count_saturated", 32'(lock_loss_count), 32'h0000_FFFF);
    drain(2);
    clr_counters = 1'b1;
    cycle(1'b0, 8'h00);
    clr_counters = 1'b0;
    chk("count_cleared", 32'(lock_loss_count), 32'd0);

    drain(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
